// File: rtl/div_pkg.sv
// Shared types and default widths for the divide/modulo issue sequencer.
// The captured-op struct is sized by the package defaults.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_REG_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  typedef struct packed {
    logic [DIV_WIDTH-1:0] a;
    logic [DIV_WIDTH-1:0] b;
    logic                 is_div;
    logic                 is_mod;
    logic [DIV_REG_W-1:0] rd;
    logic                 dbz;
  } op_t;

endpackage

// File: rtl/div_issue_ctrl_cycle_counter.sv
// Loadable down-counter with a zero flag.
// It is used to time the divider's multicycle window.
module cycle_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && count != '0) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/div_issue_ctrl.sv
// Execute-stage sequencer for div/mod instructions. It holds operands on the
// shared combinational divider for DIV_CYCLES cycles, then registers the result.
module div_issue_ctrl
  import div_pkg::*;
#(
  parameter int WIDTH      = DIV_WIDTH,
  parameter int DIV_CYCLES = 4,
  parameter int REG_W      = DIV_REG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_is_div,
  input  logic             in_is_mod,
  input  logic [REG_W-1:0] in_rd,
  input  logic             flush,
  output logic [WIDTH-1:0] div_a,
  output logic [WIDTH-1:0] div_b,
  output logic             div_is_div,
  output logic             div_is_mod,
  input  logic [WIDTH-1:0] div_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [REG_W-1:0] out_rd,
  output logic             out_div_by_zero,
  output logic             busy
);

  localparam int            CW       = $clog2(DIV_CYCLES) + 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(DIV_CYCLES - 1);

  state_t state, state_next;
  op_t    op_q;
  logic   cnt_zero;
  logic   accept;
  logic   capture;
  logic   handshake;

  assign in_ready  = !rst && (state == IDLE || (state == DONE && out_ready));
  assign accept    = in_valid && in_ready && !flush;
  assign capture   = (state == WAIT) && cnt_zero && !flush;
  assign handshake = (state == DONE) && out_ready;

  cycle_counter #(.W(CW)) u_counter (
    .clk        (clk),
    .rst        (rst),
    .load       (accept),
    .load_value (LOAD_VAL),
    .dec        (state == WAIT && !cnt_zero),
    .zero       (cnt_zero)
  );

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE: if (accept) state_next = WAIT;
        WAIT: if (cnt_zero) state_next = DONE;
        DONE: if (out_ready) state_next = accept ? WAIT : IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Operand registers feed the divider directly; flush leaves them untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op_q  <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        op_q.a      <= in_a;
        op_q.b      <= in_b;
        op_q.is_div <= in_is_div;
        op_q.is_mod <= in_is_mod;
        op_q.rd     <= in_rd;
        op_q.dbz    <= (in_b == '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid       <= 1'b0;
      out_result      <= '0;
      out_rd          <= '0;
      out_div_by_zero <= 1'b0;
    end else if (capture) begin
      out_valid       <= 1'b1;
      out_result      <= div_result;
      out_rd          <= op_q.rd;
      out_div_by_zero <= op_q.dbz;
    end else if (flush || handshake) begin
      out_valid <= 1'b0;
    end
  end

  assign div_a      = op_q.a;
  assign div_b      = op_q.b;
  assign div_is_div = op_q.is_div;
  assign div_is_mod = op_q.is_mod;
  assign busy       = (state != IDLE);

endmodule
